// File: rtl/mpt_pkg.sv
// Shared MPT/PLB types: the PLB lookup request carried on the cache address bus,
// the default arbiter requester ID, and the round-robin successor helper.
package mpt_pkg;

  localparam int PLB_ARB_NUM_REQ = 2;

  typedef logic [$clog2(PLB_ARB_NUM_REQ)-1:0] plb_arb_id_t;

  typedef struct packed {
    logic [3:0]  asid;
    logic [11:0] tag;
  } plb_lookup_req_t;

  function automatic int plb_arb_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/plb_cache_arbiter_id_fifo.sv
// plb_arb_id_fifo: in-order tracker of requester IDs for granted, unanswered cache reads.
// Pointers wrap modulo DEPTH; count is one bit wider so full and empty stay distinct.
module plb_arb_id_fifo #(
  parameter int ID_W  = 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic [ID_W-1:0]  head_id,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/plb_cache_arbiter.sv
// Shares one PLB cache read port among NUM_REQ lookup stages and steers in-order responses back.
// Define PLB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module plb_cache_arbiter
  import mpt_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = $bits(plb_lookup_req_t),
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_mem_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_mem_addr,
  input  logic [NUM_REQ-1:0]                 req_mem_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_mem_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_mem_be,
  output logic [NUM_REQ-1:0]                 req_mem_gnt,
  output logic [NUM_REQ*DATA_WIDTH-1:0]      req_mem_rdata,
  output logic [NUM_REQ-1:0]                 req_mem_valid,
  output logic                               plb_cache_mem_req,
  output logic [ADDR_WIDTH-1:0]              plb_cache_mem_addr,
  output logic                               plb_cache_mem_we,
  output logic [DATA_WIDTH-1:0]              plb_cache_mem_wdata,
  output logic [DATA_WIDTH/8-1:0]            plb_cache_mem_be,
  input  logic                               plb_cache_mem_gnt,
  input  logic [DATA_WIDTH-1:0]              plb_cache_mem_rdata,
  input  logic                               plb_cache_mem_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [ID_W-1:0] winner, head_id;
  logic            any_req, full, empty, handshake;

`ifdef PLB_ARB_FIXED_PRIO_EN
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_mem_req[i]) begin
        any_req = 1'b1;
        winner  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr, idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_req && req_mem_req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  // Pointer advances only on an accepted handshake, keeping the winner stable under a stalled gnt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          rr_ptr <= '0;
    else if (handshake) rr_ptr <= ID_W'(plb_arb_next(int'(winner), NUM_REQ));
  end
`endif

  // Issue: no full bypass, a same-cycle pop does not reopen the port.
  assign plb_cache_mem_req = any_req && !full;
  assign handshake         = plb_cache_mem_req && plb_cache_mem_gnt;
  assign req_mem_gnt       = handshake ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    plb_cache_mem_addr  = '0;
    plb_cache_mem_we    = 1'b0;
    plb_cache_mem_wdata = '0;
    plb_cache_mem_be    = '0;
    if (plb_cache_mem_req) begin
      plb_cache_mem_addr  = req_mem_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
      plb_cache_mem_we    = req_mem_we[winner];
      plb_cache_mem_wdata = req_mem_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      plb_cache_mem_be    = req_mem_be[int'(winner)*BE_W +: BE_W];
    end
  end

  plb_arb_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (handshake),
    .push_id (winner),
    .pop     (plb_cache_mem_valid),
    .head_id (head_id),
    .full    (full),
    .empty   (empty),
    .count   (outstanding_o)
  );

  // Response steering: the oldest tracked ID owns each returning beat.
  assign req_mem_valid = (plb_cache_mem_valid && !empty) ? (NUM_REQ'(1) << head_id) : '0;
  assign req_mem_rdata = plb_cache_mem_valid ? {NUM_REQ{plb_cache_mem_rdata}} : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              err_o <= 1'b0;
    else if (plb_cache_mem_valid && empty)  err_o <= 1'b1;
  end

endmodule
